// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// A word waits in the holding register while the previous word shifts out, so words
// stream with no idle bit between them. One bit advances per bit_en tick.
module piso_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,     // active-high asynchronous reset
  input  logic                  bit_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy
);

  typedef enum logic {StIdle, StShift} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hfull_q, hfull_d;

  logic act;
  logic accept;
  logic done;

  assign act    = (state_q == StShift);
  assign accept = s_valid && !hfull_q;
  assign done   = act && bit_en && (cnt_q == LastCnt);

  // Next-state: route accepted words to the shifter or the holding register.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    hfull_d = hfull_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d    = s_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (done) begin
          if (hfull_q) begin
            // Held word goes out next; a concurrent accept refills the buffer.
            sh_d    = hold_q;
            cnt_d   = '0;
            hfull_d = 1'b0;
            if (accept) begin
              hold_d  = s_data;
              hfull_d = 1'b1;
            end
          end else if (accept) begin
            sh_d  = s_data;
            cnt_d = '0;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          if (bit_en) begin
            sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (accept) begin
            hold_d  = s_data;
            hfull_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight and held word.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      hfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      hfull_q <= hfull_d;
    end
  end

  // Outputs decode straight from registers, so they are glitch-free and reset at once.
  always_comb begin
    s_ready   = !hfull_q;
    ser_valid = act;
    ser_first = act && (cnt_q == '0);
    ser_last  = act && (cnt_q == LastCnt);
    busy      = act || hfull_q;
    if (!act) begin
      ser_out = IDLE_LEVEL;
    end else if (LSB_FIRST) begin
      ser_out = sh_q[0];
    end else begin
      ser_out = sh_q[DATA_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: one MSB-first and one LSB-first instance on shared stimulus.
module tb_piso_stream;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_en;
  logic         s_valid;
  logic [W-1:0] s_data;

  logic m_ready, m_out, m_valid, m_first, m_last, m_busy;
  logic l_ready, l_out, l_valid, l_first, l_last, l_busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  piso_stream #(
    .DATA_WIDTH(W),
    .LSB_FIRST (1'b0),
    .IDLE_LEVEL(1'b0)
  ) u_dut_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .s_valid  (s_valid),
    .s_ready  (m_ready),
    .s_data   (s_data),
    .ser_out  (m_out),
    .ser_valid(m_valid),
    .ser_first(m_first),
    .ser_last (m_last),
    .busy     (m_busy)
  );

  piso_stream #(
    .DATA_WIDTH(W),
    .LSB_FIRST (1'b1),
    .IDLE_LEVEL(1'b1)
  ) u_dut_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .s_valid  (s_valid),
    .s_ready  (l_ready),
    .s_data   (s_data),
    .ser_out  (l_out),
    .ser_valid(l_valid),
    .ser_first(l_first),
    .ser_last (l_last),
    .busy     (l_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_m_out"},   32'(m_out),   32'd0);
    check_eq({tag, "_m_first"}, 32'(m_first), 32'd0);
    check_eq({tag, "_m_last"},  32'(m_last),  32'd0);
    check_eq({tag, "_m_busy"},  32'(m_busy),  32'd0);
    check_eq({tag, "_m_ready"}, 32'(m_ready), 32'd1);
    check_eq({tag, "_l_valid"}, 32'(l_valid), 32'd0);
    check_eq({tag, "_l_out"},   32'(l_out),   32'd1);
  endtask

  initial begin
    logic [7:0]  msb_seq;
    logic [7:0]  lsb_seq;
    logic [23:0] stream;
    logic [7:0]  words [3];
    logic [7:0]  rate_seq;
    logic [7:0]  r81_seq;
    int          wi;
    logic        acc;

    rst_n   = 1'b1;
    bit_en  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    check_idle("in_reset");
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle($sformatf("post_reset%0d", i));
    end

    // Single word 8'hB4, bit_en tied high. Sequences are listed in output order.
    msb_seq = 8'b1011_0100;
    lsb_seq = 8'b0010_1101;
    bit_en  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hB4;
    tick();
    s_valid = 1'b0;
    s_data  = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("sw_m_out%0d", i),   32'(m_out),   32'(msb_seq[8-i]));
      check_eq($sformatf("sw_l_out%0d", i),   32'(l_out),   32'(lsb_seq[8-i]));
      check_eq($sformatf("sw_valid%0d", i),   32'(m_valid), 32'd1);
      check_eq($sformatf("sw_first%0d", i),   32'(m_first), 32'(i == 1));
      check_eq($sformatf("sw_last%0d", i),    32'(m_last),  32'(i == 8));
      check_eq($sformatf("sw_l_first%0d", i), 32'(l_first), 32'(i == 1));
      check_eq($sformatf("sw_l_last%0d", i),  32'(l_last),  32'(i == 8));
      tick();
    end
    check_idle("sw_end");

    // Back-to-back B4, 0F, FF with s_valid held; junk data while not ready.
    words[0] = 8'hB4;
    words[1] = 8'h0F;
    words[2] = 8'hFF;
    stream   = {8'hB4, 8'h0F, 8'hFF};
    wi       = 0;
    s_valid  = 1'b1;
    s_data   = words[0];
    acc      = m_ready;
    tick();
    if (acc) wi++;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 24) begin
        check_eq($sformatf("b2b_out%0d", c),   32'(m_out),   32'(stream[24-c]));
        check_eq($sformatf("b2b_valid%0d", c), 32'(m_valid), 32'd1);
        check_eq($sformatf("b2b_first%0d", c), 32'(m_first), 32'(c % 8 == 1));
        check_eq($sformatf("b2b_last%0d", c),  32'(m_last),  32'(c % 8 == 0));
        check_eq($sformatf("b2b_ready%0d", c), 32'(m_ready),
                 32'(!((c >= 2 && c <= 8) || (c >= 10 && c <= 16))));
        check_eq($sformatf("b2b_busy%0d", c),  32'(m_busy),  32'd1);
      end else begin
        check_idle("b2b_end");
      end
      s_valid = (wi < 3);
      s_data  = (m_ready && wi < 3) ? words[wi] : 8'h5A;
      acc     = s_valid && m_ready;
      tick();
      if (acc) wi++;
    end
    check_eq("b2b_accepted", 32'(wi), 32'd3);
    s_valid = 1'b0;

    // Rate: bit_en every 4th cycle, word 8'h0F.
    rate_seq = 8'b0000_1111;
    bit_en   = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'h0F;
    tick();
    s_valid = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c <= 32) begin
        check_eq($sformatf("rate_out%0d", c),   32'(m_out),   32'(rate_seq[7-(c-1)/4]));
        check_eq($sformatf("rate_valid%0d", c), 32'(m_valid), 32'd1);
        check_eq($sformatf("rate_first%0d", c), 32'(m_first), 32'(c <= 4));
        check_eq($sformatf("rate_last%0d", c),  32'(m_last),  32'(c >= 29));
      end else begin
        check_idle("rate_end");
      end
      bit_en = (c % 4 == 0);
      tick();
    end

    // Mid-word reset with a held word, then a clean word 8'h81.
    bit_en  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hB4;
    tick();
    s_data = 8'h0F;
    tick();
    s_valid = 1'b0;
    check_eq("mw_ready_held", 32'(m_ready), 32'd0);
    check_eq("mw_busy", 32'(m_busy), 32'd1);
    tick();
    check_eq("mw_bit3", 32'(m_out), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check_idle("mw_async");
    tick();
    check_idle("mw_hold");
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("mw_after%0d", i));
    end
    r81_seq = 8'b1000_0001;
    s_valid = 1'b1;
    s_data  = 8'h81;
    tick();
    s_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("r81_m_out%0d", i), 32'(m_out),   32'(r81_seq[8-i]));
      check_eq($sformatf("r81_l_out%0d", i), 32'(l_out),   32'(r81_seq[8-i]));
      check_eq($sformatf("r81_first%0d", i), 32'(m_first), 32'(i == 1));
      check_eq($sformatf("r81_last%0d", i),  32'(m_last),  32'(i == 8));
      tick();
    end
    check_idle("r81_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
